hgcal_input_quantizer: RTL and testbench

//  Front-end stage ahead of the first LUT layer. Accepts a serial stream of HGCAL cell charges over valid/ready.

---
 rtl/hgcal_quant_pkg.sv | 28 ++
 rtl/hgcal_quant_cmp.sv | 19 +
 rtl/hgcal_input_quantizer.sv | 147 ++++++++++++++
 tb/tb_hgcal_input_quantizer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hgcal_quant_pkg.sv
`default_nettype none
// hgcal_quant_pkg: code width, default thresholds, quantizer function and assembly FSM states.
// Rev 1.0
package hgcal_quant_pkg;

  localparam int Q_W      = 2;
  localparam int THR0_DEF = 16;
  localparam int THR1_DEF = 64;
  localparam int THR2_DEF = 256;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_FULL    = 1'b1
  } asm_state_e;

  // Unsigned compare; a charge equal to a threshold takes the higher code.
  function automatic logic [Q_W-1:0] quantize(input logic [31:0] x,
                                              input logic [31:0] t0,
                                              input logic [31:0] t1,
                                              input logic [31:0] t2);
    if (x >= t2) return Q_W'(3);
    if (x >= t1) return Q_W'(2);
    if (x >= t0) return Q_W'(1);
    return Q_W'(0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hgcal_quant_cmp.sv
`default_nettype none
// hgcal_quant_cmp: combinational charge -> 2-bit code threshold comparator.
// Rev 1.0
module hgcal_quant_cmp
  import hgcal_quant_pkg::*;
#(
  parameter int IN_W = 10,
  parameter int THR0 = THR0_DEF,
  parameter int THR1 = THR1_DEF,
  parameter int THR2 = THR2_DEF
) (
  input  logic [IN_W-1:0] x_i,
  output logic [Q_W-1:0]  code_o
);

  assign code_o = quantize(32'(x_i), THR0, THR1, THR2);

endmodule
`default_nettype wire

// File: rtl/hgcal_input_quantizer.sv
`default_nettype none
// hgcal_input_quantizer: quantizes a serial charge stream and packs NUM_FEATURES codes per frame.
// Rev 1.0 -- HGCAL_QIN_DBUF_EN selects a separate assembly buffer (double buffering).
module hgcal_input_quantizer
  import hgcal_quant_pkg::*;
#(
  parameter int NUM_FEATURES = 48,
  parameter int IN_W         = 10,
  parameter int THR0         = THR0_DEF,
  parameter int THR1         = THR1_DEF,
  parameter int THR2         = THR2_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [IN_W-1:0]             s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [NUM_FEATURES*Q_W-1:0] m_data,
  output logic                        frame_err
);

  localparam int                IDX_W    = $clog2(NUM_FEATURES);
  localparam int                FW       = NUM_FEATURES * Q_W;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FEATURES - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FW-1:0]    asm_q, asm_d;
  logic [Q_W-1:0]   code;
  logic             accept, at_end, frame_end, good_last, bad_end;
  logic             frame_err_q;
  logic             m_valid_q, m_valid_d;

  hgcal_quant_cmp #(
    .IN_W (IN_W),
    .THR0 (THR0),
    .THR1 (THR1),
    .THR2 (THR2)
  ) u_cmp (
    .x_i    (s_data),
    .code_o (code)
  );

  assign accept    = s_valid && s_ready;
  assign at_end    = (idx_q == LAST_IDX);
  // A frame ends on s_last or on the last slot; only both together make a good frame.
  assign frame_end = accept && (s_last || at_end);
  assign good_last = accept && s_last && at_end;
  assign bad_end   = frame_end && !good_last;

  always_comb begin
    idx_d = idx_q;
    if (frame_end) begin
      idx_d = '0;
    end else if (accept) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    asm_d = asm_q;
    for (int k = 0; k < NUM_FEATURES; k++) begin
      if (accept && (idx_q == IDX_W'(k))) begin
        asm_d[k*Q_W +: Q_W] = code;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      frame_err_q <= bad_end;
    end
  end

`ifdef HGCAL_QIN_DBUF_EN
  asm_state_e    state_q, state_d;
  logic [FW-1:0] out_q, out_d;
  logic          load, out_free;

  assign s_ready  = (state_q == ST_COLLECT);
  assign out_free = !m_valid_q || m_ready;
  assign m_data   = out_q;

  // In FULL no sample is accepted, so asm_d equals the held frame in both states.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (good_last) begin
          if (out_free) load = 1'b1;
          else          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (m_ready) begin
          load    = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
    out_d     = load ? asm_d : out_q;
    m_valid_d = load || (m_valid_q && !m_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_COLLECT;
      asm_q     <= '0;
      out_q     <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      asm_q     <= asm_d;
      out_q     <= out_d;
      m_valid_q <= m_valid_d;
    end
  end
`else
  // The assembly register is also the output, so input waits until the frame is taken.
  assign s_ready   = !m_valid_q;
  assign m_data    = asm_q;
  assign m_valid_d = good_last || (m_valid_q && !m_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q     <= '0;
      m_valid_q <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      m_valid_q <= m_valid_d;
    end
  end
`endif

  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_hgcal_input_quantizer.sv
`default_nettype none
// tb_hgcal_input_quantizer: directed and randomized checks against a frame-level reference model.
// Rev 1.0
module tb_hgcal_input_quantizer;

  localparam int N  = 4;
  localparam int FW = 2 * N;
`ifdef HGCAL_QIN_DBUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          m_ready = 1'b1;
  logic [9:0]    s_data = '0;
  logic          s_ready, m_valid, frame_err;
  logic [FW-1:0] m_data;

  int checks = 0;
  int errors = 0;

  // Reference model: frames accepted but not yet taken downstream, plus the frame in progress.
  logic [FW-1:0] exp_q[$];
  logic [1:0]    cur[$];
  bit            err_pend = 1'b0;
  int            dut_frames = 0;
  int            dut_errs = 0;
  logic [FW-1:0] last_out = '0;
  int            bnd[8] = '{0, 15, 16, 63, 64, 255, 256, 1023};

  hgcal_input_quantizer #(
    .NUM_FEATURES (N),
    .IN_W         (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] qmodel(input int x);
    if (x >= 256) return 2'd3;
    if (x >= 64)  return 2'd2;
    if (x >= 16)  return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [FW-1:0] pack_cur();
    logic [FW-1:0] f = '0;
    for (int k = 0; k < N; k++) f[2*k +: 2] = cur[k];
    return f;
  endfunction

  // Compare process: negedge samples describe what the next rising edge will act on.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", 32'(m_data), 0);
      chk("rst_frame_err", 32'(frame_err), 0);
      chk("rst_s_ready", 32'(s_ready), 1);
      exp_q.delete();
      cur.delete();
      err_pend = 1'b0;
    end else begin
      chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
      chk("s_ready", 32'(s_ready), 32'(exp_q.size() < CAP));
      chk("frame_err", 32'(frame_err), 32'(err_pend));
      if (frame_err) dut_errs++;
      if (m_valid && exp_q.size() != 0) chk("m_data", 32'(m_data), 32'(exp_q[0]));
      if (m_valid && m_ready) begin
        dut_frames++;
        last_out = m_data;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      err_pend = 1'b0;
      if (s_valid && s_ready) begin
        cur.push_back(qmodel(int'(s_data)));
        if (s_last || cur.size() == N) begin
          if (s_last && cur.size() == N) exp_q.push_back(pack_cur());
          else err_pend = 1'b1;
          cur.delete();
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d, input bit last, input int gap);
    int n = 0;
    s_valid = 1'b1;
    s_data  = 10'(d);
    s_last  = last;
    while (1) begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 2000) begin
        errors++;
        $display("FAIL send_timeout s_ready=%0b required=1", s_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    cyc(gap);
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a, 1'b0, 0);
    send(b, 1'b0, 0);
    send(c, 1'b0, 0);
    send(d, 1'b1, 0);
  endtask

  task automatic drain();
    int n = 0;
    m_ready = 1'b1;
    while ((m_valid || exp_q.size() != 0) && n < 100) begin
      cyc(1);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL drain_timeout m_valid=%0b required=0", m_valid);
    end
    cyc(1);
  endtask

  function automatic int rval();
    if ($urandom_range(0, 1) == 0) return bnd[$urandom_range(0, 7)];
    return int'($urandom_range(0, 1023));
  endfunction

  initial begin
    int f0, e0, good, bad, r, len, gap;
    bit done;
    #1 rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    f0 = dut_frames;
    send4(0, 16, 64, 300);
    drain();
    chk("t1_frames", 32'(dut_frames - f0), 1);
    chk("t1_data", 32'(last_out), 32'h0E4);

    send4(15, 63, 255, 1023);
    drain();
    chk("t2_data", 32'(last_out), 32'h0E4);

    e0 = dut_errs;
    f0 = dut_frames;
    send(20, 1'b0, 0);
    send(70, 1'b1, 0);
    cyc(3);
    chk("t3_err_pulses", 32'(dut_errs - e0), 1);
    chk("t3_no_frame", 32'(dut_frames - f0), 0);
    send4(300, 300, 0, 64);
    drain();
    chk("t3_data", 32'(last_out), 32'h08F);

    m_ready = 1'b0;
    f0 = dut_frames;
    fork
      begin
        send4(0, 16, 64, 300);
        send4(300, 64, 16, 0);
      end
      begin
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("t4_s_ready_held", 32'(s_ready), 0);
        chk("t4_m_valid_held", 32'(m_valid), 1);
        chk("t4_m_data_held", 32'(m_data), 32'h0E4);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();
    chk("t4_frames", 32'(dut_frames - f0), 2);
    chk("t4_data", 32'(last_out), 32'h01B);

    send(300, 1'b0, 0);
    send(64, 1'b0, 0);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("t5_m_valid", 32'(m_valid), 0);
    f0 = dut_frames;
    send4(64, 0, 1023, 16);
    drain();
    chk("t5_frames", 32'(dut_frames - f0), 1);
    chk("t5_data", 32'(last_out), 32'h072);

    f0   = dut_frames;
    e0   = dut_errs;
    good = 0;
    bad  = 0;
    done = 1'b0;
    fork
      begin
        for (int fr = 0; fr < 1000; fr++) begin
          r   = int'($urandom_range(0, 19));
          gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
          if (r == 0) begin
            len = int'($urandom_range(1, N - 1));
            bad++;
            for (int i = 0; i < len; i++) send(rval(), i == len - 1, gap);
          end else if (r == 1) begin
            bad++;
            for (int i = 0; i < N; i++) send(rval(), 1'b0, gap);
          end else begin
            good++;
            for (int i = 0; i < N; i++) send(rval(), i == N - 1, gap);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    cyc(2);
    chk("t6_frames", 32'(dut_frames - f0), 32'(good));
    chk("t6_err_pulses", 32'(dut_errs - e0), 32'(bad));
    chk("t6_model_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
